// File: rtl/imm_li_expander_if.sv
// imm_li_expander request/instruction-stream bundle.
// Request handshake in, one encoded instruction word per beat out.
interface imm_li_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  modport master (
    output in_valid,
    output in_value,
    output in_rt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_rt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_last
  );
endinterface

// File: rtl/imm_li_expander.sv
// imm_li_expander: 32-bit constant -> shortest MIPS load sequence.
// Emits ADDIU, ORI, or LUI[+ORI] one word per handshake beat.
module imm_li_expander #(
  parameter bit PREFER_ADDIU = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  imm_li_expander_if.slave    bus,
  output logic [15:0]         req_count
);

  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE,
    EMIT1,
    EMIT2
  } state_t;

  state_t      state;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic [31:0] out_instr_q;
  logic [31:0] second_q;

  logic [15:0] hi;
  logic [15:0] lo;
  logic [4:0]  rt;
  logic        sext_fits;
  logic        use_addiu;
  logic        use_ori0;
  logic [31:0] first_w;
  logic [31:0] ori_w;
  logic        two_w;

  assign hi = bus.in_value[31:16];
  assign lo = bus.in_value[15:0];
  assign rt = bus.in_rt;

  // bits [31:15] all equal: a sign-extended 16-bit immediate reproduces v
  assign sext_fits = (&bus.in_value[31:15]) | ~(|bus.in_value[31:15]);
  assign use_addiu = PREFER_ADDIU && sext_fits;
  assign use_ori0  = !use_addiu && (hi == 16'h0000);
  assign ori_w     = {OP_ORI, rt, rt, lo};

  // classify the request and build the first word of its sequence
  always_comb begin
    first_w = {OP_LUI, 5'd0, rt, hi};
    two_w   = (lo != 16'h0000);
    unique case (1'b1)
      use_addiu: begin
        first_w = {OP_ADDIU, 5'd0, rt, lo};
        two_w   = 1'b0;
      end
      use_ori0: begin
        first_w = {OP_ORI, 5'd0, rt, lo};
        two_w   = 1'b0;
      end
      default: ;
    endcase
  end

  // sequencer: accept, emit first word, optionally emit the ORI tail
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_instr_q <= 32'h0;
      second_q    <= 32'h0;
      req_count   <= 16'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state       <= EMIT1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_instr_q <= first_w;
            out_last_q  <= !two_w;
            second_q    <= ori_w;
            if (req_count != 16'hFFFF)
              req_count <= req_count + 16'd1;
          end
        end
        EMIT1: begin
          if (bus.out_ready) begin
            if (!out_last_q) begin
              state       <= EMIT2;
              out_instr_q <= second_q;
              out_last_q  <= 1'b1;
            end else begin
              state       <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        EMIT2: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_imm_li_expander.sv
// Bench for imm_li_expander: both PREFER_ADDIU settings,
// scoreboard of expected words plus re-extension of emitted immediates.
module tb_imm_li_expander;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  imm_li_expander_if ia ();
  imm_li_expander_if ib ();

  imm_li_expander #(.PREFER_ADDIU(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ia.slave),
    .req_count (cnt_a)
  );

  imm_li_expander #(.PREFER_ADDIU(1'b0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (ib.slave),
    .req_count (cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int na = 0;
  int nb = 0;
  logic [32:0] sb[$];
  logic [31:0] w1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_rdy(bit s);
    return s ? ib.in_ready : ia.in_ready;
  endfunction
  function automatic logic g_ov(bit s);
    return s ? ib.out_valid : ia.out_valid;
  endfunction
  function automatic logic g_last(bit s);
    return s ? ib.out_last : ia.out_last;
  endfunction
  function automatic logic [31:0] g_instr(bit s);
    return s ? ib.out_instr : ia.out_instr;
  endfunction
  function automatic logic [15:0] g_cnt(bit s);
    return s ? cnt_b : cnt_a;
  endfunction

  task automatic set_in(input bit s, input logic vld,
                        input logic [31:0] v, input logic [4:0] rt);
    if (s) begin
      ib.in_valid = vld; ib.in_value = v; ib.in_rt = rt;
    end else begin
      ia.in_valid = vld; ia.in_value = v; ia.in_rt = rt;
    end
  endtask

  task automatic set_ordy(input bit s, input logic r);
    if (s) ib.out_ready = r;
    else ia.out_ready = r;
  endtask

  // expected words, bit 32 = last
  task automatic push_model(input bit pa, input logic [31:0] v,
                            input logic [4:0] rt);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = v[31:16];
    lo = v[15:0];
    if (pa && (v[31:15] == 17'h0 || v[31:15] == 17'h1FFFF))
      sb.push_back({1'b1, 6'b001001, 5'd0, rt, lo});
    else if (hi == 16'h0)
      sb.push_back({1'b1, 6'b001101, 5'd0, rt, lo});
    else begin
      sb.push_back({lo == 16'h0, 6'b001111, 5'd0, rt, hi});
      if (lo != 16'h0)
        sb.push_back({1'b1, 6'b001101, rt, rt, lo});
    end
  endtask

  function automatic int sat(int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic do_req(input bit s, input logic [31:0] v,
                        input logic [4:0] rt, input int hold);
    logic [32:0] e;
    logic [31:0] w;
    logic [31:0] rc;
    bit first;
    int n;
    push_model(!s, v, rt);
    n = 0;
    while (!g_rdy(s) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", g_rdy(s), 1);
    set_in(s, 1'b1, v, rt);
    set_ordy(s, hold == 0);
    @(negedge clk);
    set_in(s, 1'b0, ~v, ~rt);
    if (s) nb++;
    else na++;
    chk("req_count", g_cnt(s), sat(s ? nb : na));
    rc = 32'h0;
    first = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", g_ov(s), 1);
      chk("in_ready_busy", g_rdy(s), 0);
      chk("out_instr", g_instr(s), e[31:0]);
      chk("out_last", g_last(s), e[32]);
      w = g_instr(s);
      if (first) begin
        w1 = w;
        if (hold > 0) begin
          for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", g_ov(s), 1);
            chk("hold_instr", g_instr(s), w);
            chk("hold_last", g_last(s), e[32]);
            chk("hold_in_ready", g_rdy(s), 0);
          end
          set_ordy(s, 1'b1);
        end
      end
      first = 1'b0;
      case (w[31:26])
        6'b001001: rc = {{16{w[15]}}, w[15:0]};
        6'b001101: rc = rc | {16'h0, w[15:0]};
        6'b001111: rc = {w[15:0], 16'h0};
        default:   rc = ~v;
      endcase
      @(negedge clk);
    end
    chk("idle_valid", g_ov(s), 0);
    chk("idle_ready", g_rdy(s), 1);
    chk("reextend", rc, v);
  endtask

  logic [31:0] vec[14];

  initial begin
    vec[0]  = 32'h00000000; vec[1]  = 32'h00000005;
    vec[2]  = 32'hFFFF8000; vec[3]  = 32'h0000ABCD;
    vec[4]  = 32'h12345678; vec[5]  = 32'h00010000;
    vec[6]  = 32'h00007FFF; vec[7]  = 32'h00008000;
    vec[8]  = 32'hFFFFFFFF; vec[9]  = 32'hFFFF7FFF;
    vec[10] = 32'h80000000; vec[11] = 32'h7FFF0000;
    vec[12] = 32'hDEADBEEF; vec[13] = 32'hFFFE0001;

    set_in(0, 1'b0, 32'h0, 5'd0);
    set_in(1, 1'b0, 32'h0, 5'd0);
    set_ordy(0, 1'b1);
    set_ordy(1, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_last", ia.out_last, 0);
    chk("rst_out_instr", ia.out_instr, 0);
    chk("rst_req_count", cnt_a, 0);
    chk("rst0_out_valid", ib.out_valid, 0);
    chk("rst0_req_count", cnt_b, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(0, 32'h00000005, 5'd8, 0);
    chk("spec_addiu5", w1, 32'h24080005);
    do_req(0, 32'hFFFF8000, 5'd9, 0);
    chk("spec_addiu_neg", w1, 32'h24098000);
    do_req(1, 32'hFFFF8000, 5'd9, 0);
    chk("spec_lui_neg", w1, 32'h3C09FFFF);
    do_req(0, 32'h0000ABCD, 5'd10, 0);
    chk("spec_ori", w1, 32'h340AABCD);
    do_req(0, 32'h12345678, 5'd4, 0);
    chk("spec_lui_ori", w1, 32'h3C041234);
    do_req(0, 32'h00010000, 5'd2, 0);
    chk("spec_lui_only", w1, 32'h3C020001);
    do_req(0, 32'h00000000, 5'd0, 0);
    chk("spec_zero_addiu", w1, 32'h24000000);
    do_req(1, 32'h00000000, 5'd3, 0);
    chk("spec_zero_ori", w1, 32'h34030000);
    do_req(0, 32'h12345678, 5'd4, 3);

    for (int i = 0; i < 14; i++) begin
      do_req(0, vec[i], 5'(i + 17), 0);
      do_req(1, vec[i], 5'(i + 1), 0);
    end
    for (int i = 0; i < 6; i++) begin
      do_req(0, $urandom, 5'($urandom_range(0, 31)), 0);
      do_req(1, $urandom, 5'($urandom_range(0, 31)), 0);
    end

    set_in(0, 1'b1, 32'h12345678, 5'd4);
    set_ordy(0, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0, 5'd0);
    chk("pre_rst_valid", ia.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    na = 0;
    nb = 0;
    set_ordy(0, 1'b1);
    chk("mid_rst_valid", ia.out_valid, 0);
    chk("mid_rst_ready", ia.in_ready, 1);
    chk("mid_rst_count", cnt_a, 0);
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_quiet", ia.out_valid, 0);
    end

    for (int i = 0; i < 20; i++)
      do_req(0, 32'h00000100 + 32'(i), 5'd5, 0);
    chk("b2b_count", cnt_a, 20);

    force dut.req_count = 16'hFFFD;
    @(negedge clk);
    release dut.req_count;
    na = 65533;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      do_req(0, 32'hCAFE0000, 5'd7, 0);
    chk("sat_count", cnt_a, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
